// File: rtl/sa_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_feeder_pkg : shared types and size helpers for the tile feeder    |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
package sa_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARST   = 3'd1,
        FEED   = 3'd2,
        DONE   = 3'd3,
        RESULT = 3'd4
    } state_t;

    function automatic int calc_rows(input int sys_height, input int arr_height);
        return sys_height * arr_height;
    endfunction

    function automatic int calc_cols(input int sys_width, input int arr_width);
        return sys_width * arr_width;
    endfunction

    function automatic int calc_kw(input int max_k);
        return $clog2(max_k + 1);
    endfunction

    function automatic int calc_aw(input int max_k);
        return (max_k > 1) ? $clog2(max_k) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_beat_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_beat_buffer : MAX_K-deep beat store, one write port, registered   |
// |                  read port that holds its value when not reading     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module sa_beat_buffer
    import sa_feeder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int MAX_K = 16,
    localparam int AW   = calc_aw(MAX_K),
    localparam int DW   = (ROWS + COLS) * WIDTH
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [MAX_K];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The read register doubles as the array-facing output register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sa_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sa_tile_feeder : buffers A/B beats and streams them into a systolic  |
// |                  array, then returns the captured result tile        |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module sa_tile_feeder
    import sa_feeder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 1,
    parameter int MAX_K      = 16,
    parameter int TIMEOUT    = 1024,
    localparam int ROWS      = calc_rows(SYS_HEIGHT, ARR_HEIGHT),
    localparam int COLS      = calc_cols(SYS_WIDTH, ARR_WIDTH),
    localparam int KW        = calc_kw(MAX_K)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [KW-1:0]              cfg_k,
    input  logic                       cfg_accum,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [ROWS*WIDTH-1:0]      load_a,
    input  logic [COLS*WIDTH-1:0]      load_b,
    input  logic                       start,
    output logic                       busy,
    output logic                       sa_reset,
    output logic [ROWS*WIDTH-1:0]      sa_in_a,
    output logic [COLS*WIDTH-1:0]      sa_in_b,
    output logic                       sa_in_done,
    input  logic                       sa_calc_done,
    input  logic [ROWS*COLS*WIDTH-1:0] sa_out_c,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ROWS*COLS*WIDTH-1:0] res_data,
    output logic                       err_k,
    output logic                       err_timeout
);

    localparam int AW = calc_aw(MAX_K);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t                       r_state;
    state_t                       w_next;
    logic [KW-1:0]                r_wr_cnt;
    logic [KW-1:0]                r_rd_ptr;
    logic [KW-1:0]                r_k;
    logic [TW-1:0]                r_timer;
    logic                         r_sa_reset;
    logic                         r_in_done;
    logic                         r_res_valid;
    logic [ROWS*COLS*WIDTH-1:0]   r_res_data;
    logic                         r_err_k;
    logic                         r_err_to;
    logic                         w_idle;
    logic                         w_load;
    logic                         w_start_ok;
    logic                         w_err_k;
    logic                         w_timeout;
    logic                         w_rd_en;
    logic [(ROWS+COLS)*WIDTH-1:0] w_rd_data;

    assign w_idle     = (r_state == IDLE);
    assign load_ready = w_idle && !start && (r_wr_cnt < KW'(MAX_K));
    assign w_load     = load_valid && load_ready;
    assign w_start_ok = w_idle && start && (cfg_k != '0) && (cfg_k <= r_wr_cnt);
    assign w_err_k    = w_idle && start && !w_start_ok;
    assign w_timeout  = (r_state == DONE) && !sa_calc_done && (r_timer == TW'(TIMEOUT - 1));
    assign busy       = !w_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Reads are issued one cycle ahead so each beat lands in FEED.
    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next  = cfg_accum ? FEED : ARST;
                    w_rd_en = cfg_accum;
                end
            end
            ARST: begin
                w_next  = FEED;
                w_rd_en = 1'b1;
            end
            FEED: begin
                if (r_rd_ptr == r_k) begin
                    w_next = DONE;
                end else begin
                    w_rd_en = 1'b1;
                end
            end
            DONE: begin
                if (sa_calc_done) begin
                    w_next = RESULT;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_k         <= '0;
            r_timer     <= '0;
            r_sa_reset  <= 1'b1;
            r_in_done   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err_k     <= 1'b0;
            r_err_to    <= 1'b0;
        end else begin
            r_sa_reset  <= (w_next == ARST);
            r_in_done   <= (w_next == DONE);
            r_res_valid <= (w_next == RESULT);
            r_err_k     <= w_err_k;
            r_err_to    <= w_timeout;
            if (w_load) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_start_ok) begin
                r_k <= cfg_k;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (r_state == DONE) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
            if ((r_state == DONE) && sa_calc_done) begin
                r_res_data <= sa_out_c;
            end
            // Any return to IDLE from a run discards the buffered tile.
            if (!w_idle && (w_next == IDLE)) begin
                r_wr_cnt <= '0;
                r_rd_ptr <= '0;
            end
        end
    end

    sa_beat_buffer #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .COLS  (COLS),
        .MAX_K (MAX_K)
    ) u_buffer (
        .clk       (clk),
        .i_rst     (reset),
        .i_wr_en   (w_load),
        .i_wr_addr (r_wr_cnt[AW-1:0]),
        .i_wr_data ({load_a, load_b}),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    assign {sa_in_a, sa_in_b} = w_rd_data;
    assign sa_reset    = r_sa_reset;
    assign sa_in_done  = r_in_done;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign err_k       = r_err_k;
    assign err_timeout = r_err_to;

endmodule
`default_nettype wire

// File: tb/tb_sa_tile_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sa_tile_feeder : scoreboard bench with an accumulating array stub |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_sa_tile_feeder;

    localparam int W     = 16;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int MAX_K = 16;
    localparam int KW    = 5;
    localparam int TO    = 32;
    localparam int CW    = ROWS * COLS * W;

    logic               clk = 1'b0;
    logic               reset;
    logic [KW-1:0]      cfg_k;
    logic               cfg_accum;
    logic               load_valid;
    logic               load_ready;
    logic [ROWS*W-1:0]  load_a;
    logic [COLS*W-1:0]  load_b;
    logic               start;
    logic               busy;
    logic               sa_reset;
    logic [ROWS*W-1:0]  sa_in_a;
    logic [COLS*W-1:0]  sa_in_b;
    logic               sa_in_done;
    logic               sa_calc_done;
    logic [CW-1:0]      sa_out_c;
    logic               res_valid;
    logic               res_ready;
    logic [CW-1:0]      res_data;
    logic               err_k;
    logic               err_timeout;

    int tests = 0;
    int fails = 0;

    logic [ROWS*W-1:0] ma [MAX_K];
    logic [COLS*W-1:0] mb [MAX_K];
    int                m_wr = 0;
    logic [CW-1:0]     prev_c;
    bit                prev_ok = 0;
    bit                to_expected = 0;
    bit                stub_hang = 0;
    int                stub_dly = 0;

    logic [ROWS*W-1:0] bq_a [$];
    logic [COLS*W-1:0] bq_b [$];
    logic [CW-1:0]     rq   [$];

    sa_tile_feeder #(
        .WIDTH(W), .ARR_HEIGHT(4), .ARR_WIDTH(4), .SYS_HEIGHT(1), .SYS_WIDTH(1),
        .MAX_K(MAX_K), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .cfg_k(cfg_k), .cfg_accum(cfg_accum),
        .load_valid(load_valid), .load_ready(load_ready), .load_a(load_a), .load_b(load_b),
        .start(start), .busy(busy), .sa_reset(sa_reset), .sa_in_a(sa_in_a), .sa_in_b(sa_in_b),
        .sa_in_done(sa_in_done), .sa_calc_done(sa_calc_done), .sa_out_c(sa_out_c),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err_k(err_k), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Integer outer-product array stand-in: clears on sa_reset, accumulates each fed beat.
    logic [W-1:0] stub_acc [ROWS*COLS];
    int           stub_cnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            sa_calc_done <= 1'b0;
            sa_out_c     <= '0;
            stub_cnt     <= 0;
        end else if (sa_calc_done) begin
            sa_calc_done <= 1'b0;
        end else if (sa_in_done && !stub_hang) begin
            if (stub_cnt >= stub_dly) begin
                sa_calc_done <= 1'b1;
                for (int i = 0; i < ROWS*COLS; i++) sa_out_c[i*W +: W] <= stub_acc[i];
                stub_cnt <= 0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end else begin
            stub_cnt <= 0;
        end
        if (sa_reset) begin
            for (int i = 0; i < ROWS*COLS; i++) stub_acc[i] <= '0;
        end else if (busy && !sa_in_done && !res_valid) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    stub_acc[r*COLS+c] <= stub_acc[r*COLS+c] + sa_in_a[r*W +: W] * sa_in_b[c*W +: W];
        end
    end

    // Monitor: pops expected beats and results as the DUT presents them.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !sa_reset && !sa_in_done && !res_valid) begin
                if (bq_a.size() == 0) begin
                    check("beat_unexpected", 1, 0);
                end else begin
                    check("beat_a", sa_in_a, bq_a.pop_front());
                    check("beat_b", sa_in_b, bq_b.pop_front());
                end
            end
            if (res_valid && res_ready) begin
                if (rq.size() == 0) check("result_unexpected", 1, 0);
                else check("res_data", res_data, rq.pop_front());
            end
            if (err_timeout && !to_expected) check("err_timeout_unexpected", 1, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n);
        logic [ROWS*W-1:0] a;
        logic [COLS*W-1:0] b;
        bit                rdy;
        for (int i = 0; i < n; i++) begin
            for (int e = 0; e < ROWS; e++) a[e*W +: W] = W'($urandom());
            for (int e = 0; e < COLS; e++) b[e*W +: W] = W'($urandom());
            load_a = a; load_b = b; load_valid = 1'b1;
            @(negedge clk);
            rdy = (m_wr < MAX_K);
            check("load_ready", load_ready, rdy);
            if (rdy) begin
                ma[m_wr] = a; mb[m_wr] = b; m_wr++;
            end
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic push_beats(input int k);
        for (int i = 0; i < k; i++) begin
            bq_a.push_back(ma[i]);
            bq_b.push_back(mb[i]);
        end
    endtask

    task automatic run(input int k, input bit acc, input int hold);
        bit            ok;
        int            lat;
        int            cyc;
        logic [CW-1:0] ex;
        ok = (k != 0) && (k <= m_wr);
        stub_dly = $urandom_range(0, 4);
        ex = '0;
        if (ok) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    logic [W-1:0] s;
                    s = acc ? prev_c[(r*COLS+c)*W +: W] : '0;
                    for (int kk = 0; kk < k; kk++) s = s + ma[kk][r*W +: W] * mb[kk][c*W +: W];
                    ex[(r*COLS+c)*W +: W] = s;
                end
            end
            push_beats(k);
            rq.push_back(ex);
        end
        cfg_k = KW'(k); cfg_accum = acc; start = 1'b1;
        @(negedge clk);
        check("start_blocks_load", load_ready, 0);
        step();
        start = 1'b0;
        @(negedge clk);
        check("err_k", err_k, !ok);
        check("busy_after_start", busy, ok);
        if (!ok) begin
            check("load_ready_after_err", load_ready, m_wr < MAX_K);
            step();
            return;
        end
        check("sa_reset_first", sa_reset, !acc);
        lat = acc ? k + 1 : k + 2;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            check("in_done_timing", sa_in_done, c == lat);
            if (c > 1) check("sa_reset_feed", sa_reset, 0);
            if (c == lat) check("hold_last_beat", sa_in_a, ma[k-1]);
        end
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("res_valid_seen", res_valid, 1);
        for (int h = 0; h < hold; h++) begin
            step();
            @(negedge clk);
            check("res_hold_valid", res_valid, 1);
            check("res_hold_data", res_data, ex);
        end
        step();
        res_ready = 1'b1;
        @(negedge clk);
        check("busy_in_result", busy, 1);
        step();
        res_ready = 1'b0;
        @(negedge clk);
        check("busy_after_ready", busy, 0);
        check("load_ready_after_run", load_ready, 1);
        m_wr    = 0;
        prev_c  = ex;
        prev_ok = 1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int cyc;
        reset = 1'b1; cfg_k = '0; cfg_accum = 1'b0; load_valid = 1'b0;
        load_a = '0; load_b = '0; start = 1'b0; res_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sa_reset", sa_reset, 1);
        check("rst_in_a", sa_in_a, 0);
        check("rst_in_b", sa_in_b, 0);
        check("rst_in_done", sa_in_done, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_err_k", err_k, 0);
        check("rst_err_to", err_timeout, 0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("sa_reset_released", sa_reset, 0);
        check("load_ready_idle", load_ready, 1);
        step();

        // Bad K starts keep the buffer, then a good start runs.
        load(5);
        run(0, 0, 0);
        run(6, 0, 0);
        run(5, 0, 2);

        // Split-K across two runs.
        load(4);
        run(4, 0, 1);
        load(4);
        run(4, 1, 0);

        // Full buffer: 17th beat refused.
        load(17);
        run(16, 0, 0);

        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, MAX_K);
            load(n);
            k = $urandom_range(1, n);
            run(k, prev_ok && ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
        end

        // calc_done never arrives.
        load(2);
        push_beats(2);
        stub_hang = 1;
        cfg_k = KW'(2); cfg_accum = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!sa_in_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("to_in_done_rise", cyc, 4);
        to_expected = 1;
        n = 0;
        while (!err_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_distance", n, TO);
        check("to_busy", busy, 0);
        check("to_load_ready", load_ready, 1);
        check("to_in_done", sa_in_done, 0);
        step();
        to_expected = 0;
        stub_hang = 0;
        m_wr = 0;
        prev_ok = 0;

        // Reset during beat 2 of 5.
        load(5);
        push_beats(5);
        cfg_k = KW'(5); cfg_accum = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        check("beat2_before_reset", sa_in_a, ma[2]);
        step();
        reset = 1'b0;
        bq_a.delete();
        bq_b.delete();
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_done", sa_in_done, 0);
        check("mid_rst_in_a", sa_in_a, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_load_ready", load_ready, 1);
        m_wr = 0;
        prev_ok = 0;
        step();
        run(1, 0, 0);
        load(3);
        run(3, 0, 10);

        check("beat_queue_empty", bq_a.size(), 0);
        check("res_queue_empty", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
